// File: rtl/angle_shoot_gen.sv
`default_nettype none
// ============================================================================
// Module : angle_shoot_gen
// Brief  : Phase-accumulator angle/shoot reference for the modulator, with a
//          double-buffered step and a sync re-zero for multi-module alignment.
// Rev    : 1.0  initial release
// ============================================================================
module angle_shoot_gen #(
    parameter int          CLK_PER_SHOOT = 100,
    parameter int          SHOOT_LEN     = 50,
    parameter int          ACC_WIDTH     = 24,
    parameter logic [11:0] ANGLE_OFFSET  = 12'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] step_in,
    input  logic                 step_load,
    input  logic                 sync_in,
    output logic [11:0]          angle,
    output logic                 shoot,
    output logic                 wrap
);

    localparam int TICK_W = $clog2(CLK_PER_SHOOT);
    localparam int SCNT_W = $clog2(SHOOT_LEN + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_SHOOT - 1);
    localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SHOOT_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] step_active;
    logic [ACC_WIDTH-1:0] step_pending;
    logic [TICK_W-1:0]    tick;
    logic [SCNT_W-1:0]    shoot_cnt;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [11:0]          angle_next;

    // The extra top bit of the sum is the carry that drives wrap.
    assign acc_sum    = {1'b0, acc} + {1'b0, step_active};
    assign angle_next = acc_sum[ACC_WIDTH-1 -: 12] + ANGLE_OFFSET;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            step_active  <= '0;
            step_pending <= '0;
            tick         <= '0;
            shoot_cnt    <= '0;
            angle        <= '0;
            shoot        <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            if (step_load) begin
                step_pending <= step_in;
            end

            case (state)
                IDLE: begin
                    tick      <= '0;
                    shoot_cnt <= '0;
                    shoot     <= 1'b0;
                    wrap      <= 1'b0;
                    if (sync_in) begin
                        acc   <= '0;
                        angle <= ANGLE_OFFSET;
                    end
                    if (enable) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // Dropping enable beats sync and terminal count alike.
                        state     <= IDLE;
                        tick      <= '0;
                        shoot_cnt <= '0;
                        shoot     <= 1'b0;
                        wrap      <= 1'b0;
                    end else if (sync_in) begin
                        acc       <= '0;
                        tick      <= '0;
                        shoot_cnt <= '0;
                        shoot     <= 1'b0;
                        wrap      <= 1'b0;
                        angle     <= ANGLE_OFFSET;
                    end else begin
                        wrap <= 1'b0;
                        if (tick == TICK_LAST) begin
                            tick        <= '0;
                            acc         <= acc_sum[ACC_WIDTH-1:0];
                            angle       <= angle_next;
                            shoot       <= 1'b1;
                            shoot_cnt   <= SCNT_INIT;
                            wrap        <= acc_sum[ACC_WIDTH];
                            step_active <= step_pending;
                        end else begin
                            tick <= tick + TICK_W'(1);
                            if (shoot) begin
                                if (shoot_cnt == '0) begin
                                    shoot <= 1'b0;
                                end else begin
                                    shoot_cnt <= shoot_cnt - SCNT_W'(1);
                                end
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
